// File: rtl/tile_grid_renderer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tile_grid_renderer_pkg: cell codes, sprite indices, colours      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package tile_grid_renderer_pkg;

    localparam int LATENCY = 4;

    typedef enum logic [1:0] {
        GS_PLAY = 2'd0,
        GS_WON  = 2'd1,
        GS_LOST = 2'd2,
        GS_RSVD = 2'd3
    } game_state_t;

    localparam logic [4:0] CODE_OPEN     = 5'b00000;
    localparam logic [4:0] CODE_NUM_MIN  = 5'b00001;
    localparam logic [4:0] CODE_NUM_MAX  = 5'b01000;
    localparam logic [4:0] CODE_MINE     = 5'b01001;
    localparam logic [4:0] CODE_EXPLODED = 5'b01010;
    localparam logic [4:0] CODE_COVER    = 5'b10000;
    localparam logic [4:0] CODE_FLAG     = 5'b10001;

    localparam logic [3:0] SPR_OPEN     = 4'd0;
    localparam logic [3:0] SPR_MINE     = 4'd9;
    localparam logic [3:0] SPR_COVER    = 4'd10;
    localparam logic [3:0] SPR_FLAG     = 4'd11;
    localparam logic [3:0] SPR_EXPLODED = 4'd12;

    localparam logic [11:0] COL_BLACK  = 12'h000;
    localparam logic [11:0] COL_CURSOR = 12'hF00;
    localparam logic [11:0] COL_ERROR  = 12'hF0F;
    localparam logic [11:0] COL_BG     = 12'hFFF;
    localparam logic [11:0] COL_BORDER = 12'h888;
    localparam logic [11:0] COL_WON    = 12'h0F0;
    localparam logic [11:0] COL_LOST   = 12'hF00;

endpackage
`default_nettype wire

// File: rtl/tile_grid_renderer_sprite_map.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tile_sprite_map: board cell code -> {valid, sprite index}        |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tile_sprite_map
    import tile_grid_renderer_pkg::*;
(
    input  logic [4:0] code,
    output logic       valid,
    output logic [3:0] sprite_idx
);

    always_comb begin
        valid      = 1'b1;
        sprite_idx = SPR_OPEN;
        if (code == CODE_OPEN) begin
            sprite_idx = SPR_OPEN;
        end else if (code >= CODE_NUM_MIN && code <= CODE_NUM_MAX) begin
            sprite_idx = code[3:0];
        end else if (code == CODE_MINE) begin
            sprite_idx = SPR_MINE;
        end else if (code == CODE_COVER) begin
            sprite_idx = SPR_COVER;
        end else if (code == CODE_FLAG) begin
            sprite_idx = SPR_FLAG;
        end else if (code == CODE_EXPLODED) begin
            sprite_idx = SPR_EXPLODED;
        end else begin
            valid = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tile_grid_renderer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tile_grid_renderer: 4-stage pixel pipeline, grid->RAM->ROM->rgb  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tile_grid_renderer
    import tile_grid_renderer_pkg::*;
#(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 16,
    parameter int TILE_LOG2  = 5,
    parameter int ORIGIN_X   = 144,
    parameter int ORIGIN_Y   = 13,
    parameter int CURSOR_T   = 4,
    parameter int BORDER_T   = 4,
    parameter int BLINK_LOG2 = 24
) (
    input  logic                               masterclk,
    input  logic                               rst,
    input  logic                               bright,
    input  logic [9:0]                         hCount,
    input  logic [9:0]                         vCount,
    input  logic [$clog2(GRID_W)-1:0]          cursor_x,
    input  logic [$clog2(GRID_H)-1:0]          cursor_y,
    input  logic [1:0]                         game_state,
    output logic [$clog2(GRID_W*GRID_H)-1:0]   cell_addr,
    input  logic [4:0]                         cell_data,
    output logic [4+2*TILE_LOG2-1:0]           sprite_addr,
    input  logic [11:0]                        sprite_data,
    output logic [11:0]                        rgb,
    output logic                               bright_out
);

    localparam int CXW    = $clog2(GRID_W);
    localparam int CYW    = $clog2(GRID_H);
    localparam int CAW    = $clog2(GRID_W*GRID_H);
    localparam int TILE   = 2**TILE_LOG2;
    localparam int XW     = CXW + TILE_LOG2;
    localparam int YW     = CYW + TILE_LOG2;
    localparam int GX_END = ORIGIN_X + GRID_W*TILE;
    localparam int GY_END = ORIGIN_Y + GRID_H*TILE;

    logic [BLINK_LOG2-1:0] blink_cnt;
    logic [CXW-1:0]        cur_x;
    logic [CYW-1:0]        cur_y;

    // Input register stage: pixel, flag and game state travel together
    logic [9:0]         s0_h, s0_v;
    logic               s0_bright;
    game_state_t        s0_gs;

    logic               s1_in_grid, s1_bright, s1_cursor, s1_border, s1_blink;
    logic [CXW-1:0]     s1_col;
    logic [CYW-1:0]     s1_row;
    logic [TILE_LOG2-1:0] s1_ox, s1_oy;
    game_state_t        s1_gs;

    logic               s2_in_grid, s2_bright, s2_cursor, s2_border, s2_blink;
    logic [TILE_LOG2-1:0] s2_ox, s2_oy;
    game_state_t        s2_gs;

    logic               s3_in_grid, s3_valid, s3_bright, s3_cursor, s3_border, s3_blink;
    game_state_t        s3_gs;

    int                 h_i, v_i;
    logic [XW-1:0]      dx;
    logic [YW-1:0]      dy;
    logic [CXW-1:0]     col_n;
    logic [CYW-1:0]     row_n;
    logic [TILE_LOG2-1:0] ox_n, oy_n;
    logic               in_grid_n, near_edge_n, cursor_n, border_n, cur_ok;
    logic               map_valid, cursor_on;
    logic [3:0]         map_idx;
    logic [11:0]        rgb_n;

    // Bounds are checked on the unsubtracted coordinate so nothing left of
    // or above the grid can wrap into a valid cell.
    always_comb begin
        h_i         = int'(s0_h);
        v_i         = int'(s0_v);
        in_grid_n   = (h_i >= ORIGIN_X) && (h_i < GX_END) &&
                      (v_i >= ORIGIN_Y) && (v_i < GY_END);
        dx          = XW'(h_i - ORIGIN_X);
        dy          = YW'(v_i - ORIGIN_Y);
        col_n       = dx[XW-1:TILE_LOG2];
        row_n       = dy[YW-1:TILE_LOG2];
        ox_n        = dx[TILE_LOG2-1:0];
        oy_n        = dy[TILE_LOG2-1:0];
        near_edge_n = (ox_n < TILE_LOG2'(CURSOR_T)) || (ox_n >= TILE_LOG2'(TILE-CURSOR_T)) ||
                      (oy_n < TILE_LOG2'(CURSOR_T)) || (oy_n >= TILE_LOG2'(TILE-CURSOR_T));
        cur_ok      = (int'(cur_x) < GRID_W) && (int'(cur_y) < GRID_H);
        cursor_n    = in_grid_n && cur_ok && (col_n == cur_x) && (row_n == cur_y) && near_edge_n;
        border_n    = !in_grid_n &&
                      (h_i >= ORIGIN_X - BORDER_T) && (h_i < GX_END + BORDER_T) &&
                      (v_i >= ORIGIN_Y - BORDER_T) && (v_i < GY_END + BORDER_T);
    end

    assign cell_addr = CAW'(int'(s1_row)*GRID_W + int'(s1_col));

    tile_sprite_map u_map (
        .code       (cell_data),
        .valid      (map_valid),
        .sprite_idx (map_idx)
    );

    assign sprite_addr = {map_idx, s2_oy, s2_ox};

    always_comb begin
        cursor_on = ((s3_gs == GS_PLAY) || (s3_gs == GS_RSVD)) && !s3_blink;
        rgb_n     = COL_BG;
        if (!s3_bright) begin
            rgb_n = COL_BLACK;
        end else if (s3_cursor && cursor_on) begin
            rgb_n = COL_CURSOR;
        end else if (s3_in_grid) begin
            rgb_n = s3_valid ? sprite_data : COL_ERROR;
        end else if (s3_border) begin
            case (s3_gs)
                GS_WON:  rgb_n = s3_blink ? COL_BORDER : COL_WON;
                GS_LOST: rgb_n = COL_LOST;
                default: rgb_n = COL_BORDER;
            endcase
        end
    end

    always_ff @(posedge masterclk or negedge rst) begin
        if (!rst) begin
            blink_cnt  <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            s0_h       <= '0;
            s0_v       <= '0;
            s0_bright  <= 1'b0;
            s0_gs      <= GS_PLAY;
            s1_in_grid <= 1'b0;
            s1_bright  <= 1'b0;
            s1_cursor  <= 1'b0;
            s1_border  <= 1'b0;
            s1_blink   <= 1'b0;
            s1_col     <= '0;
            s1_row     <= '0;
            s1_ox      <= '0;
            s1_oy      <= '0;
            s1_gs      <= GS_PLAY;
            s2_in_grid <= 1'b0;
            s2_bright  <= 1'b0;
            s2_cursor  <= 1'b0;
            s2_border  <= 1'b0;
            s2_blink   <= 1'b0;
            s2_ox      <= '0;
            s2_oy      <= '0;
            s2_gs      <= GS_PLAY;
            s3_in_grid <= 1'b0;
            s3_valid   <= 1'b0;
            s3_bright  <= 1'b0;
            s3_cursor  <= 1'b0;
            s3_border  <= 1'b0;
            s3_blink   <= 1'b0;
            s3_gs      <= GS_PLAY;
            rgb        <= COL_BLACK;
            bright_out <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt + BLINK_LOG2'(1);
            if (hCount == 10'd0 && vCount == 10'd0) begin
                cur_x <= cursor_x;
                cur_y <= cursor_y;
            end
            s0_h       <= hCount;
            s0_v       <= vCount;
            s0_bright  <= bright;
            s0_gs      <= game_state_t'(game_state);

            s1_in_grid <= in_grid_n;
            s1_bright  <= s0_bright;
            s1_cursor  <= cursor_n;
            s1_border  <= border_n;
            s1_blink   <= blink_cnt[BLINK_LOG2-1];
            s1_col     <= col_n;
            s1_row     <= row_n;
            s1_ox      <= ox_n;
            s1_oy      <= oy_n;
            s1_gs      <= s0_gs;

            s2_in_grid <= s1_in_grid;
            s2_bright  <= s1_bright;
            s2_cursor  <= s1_cursor;
            s2_border  <= s1_border;
            s2_blink   <= s1_blink;
            s2_ox      <= s1_ox;
            s2_oy      <= s1_oy;
            s2_gs      <= s1_gs;

            s3_in_grid <= s2_in_grid;
            s3_valid   <= map_valid;
            s3_bright  <= s2_bright;
            s3_cursor  <= s2_cursor;
            s3_border  <= s2_border;
            s3_blink   <= s2_blink;
            s3_gs      <= s2_gs;

            rgb        <= rgb_n;
            bright_out <= s3_bright;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_grid_renderer.sv
`default_nettype none
// Bench for tile_grid_renderer: directed table plus random pixels against a
// pixel-level reference model with RAM/ROM models attached.
module tb_tile_grid_renderer;

    localparam int GW = 16, GH = 16, TS = 32, OX = 144, OY = 13;
    localparam int CT = 4, BT = 4, BL = 4;

    logic        masterclk = 1'b0;
    logic        rst = 1'b1;
    logic        bright = 1'b0;
    logic [9:0]  hCount = '0, vCount = '0;
    logic [3:0]  cursor_x = '0, cursor_y = '0;
    logic [1:0]  game_state = '0;
    logic [7:0]  cell_addr;
    logic [4:0]  cell_data;
    logic [13:0] sprite_addr;
    logic [11:0] sprite_data;
    logic [11:0] rgb;
    logic        bright_out;

    tile_grid_renderer #(
        .GRID_W(GW), .GRID_H(GH), .TILE_LOG2(5), .ORIGIN_X(OX), .ORIGIN_Y(OY),
        .CURSOR_T(CT), .BORDER_T(BT), .BLINK_LOG2(BL)
    ) dut (
        .masterclk(masterclk), .rst(rst), .bright(bright),
        .hCount(hCount), .vCount(vCount),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .game_state(game_state),
        .cell_addr(cell_addr), .cell_data(cell_data),
        .sprite_addr(sprite_addr), .sprite_data(sprite_data),
        .rgb(rgb), .bright_out(bright_out)
    );

    always #5 masterclk = ~masterclk;

    logic [4:0] ram [256];

    function automatic logic [11:0] rom_fn(input logic [13:0] a);
        logic [13:0] t;
        t = (a * 14'd37) ^ (a >> 2);
        return t[11:0] ^ 12'h5A3;
    endfunction

    always @(posedge masterclk) begin
        cell_data   <= ram[cell_addr];
        sprite_data <= rom_fn(sprite_addr);
    end

    int nvec = 0, nmis = 0;
    int edge_k = 0;
    int lat_cx = 0, lat_cy = 0;

    typedef struct { logic [11:0] rgb; logic br; } exp_t;
    typedef struct { bit cchk; int caddr; bit schk; logic [13:0] saddr; } adr_t;
    exp_t eq[$];
    adr_t aq[$];

    typedef struct { int h; int v; bit br; int cx; int cy; int gs; int blk; logic [11:0] exp; string name; } vec_t;
    vec_t tbl[$];

    function automatic int sprite_of(input int code);
        if (code == 0) return 0;
        if (code >= 1 && code <= 8) return code;
        if (code == 9) return 9;
        if (code == 16) return 10;
        if (code == 17) return 11;
        if (code == 10) return 12;
        return -1;
    endfunction

    function automatic bit in_grid(input int h, input int v);
        return h >= OX && h < OX + GW*TS && v >= OY && v < OY + GH*TS;
    endfunction

    function automatic logic [11:0] ref_rgb(input int h, input int v, input bit br,
                                            input int cx, input int cy, input int gs, input bit blink);
        int col, row, ox, oy, idx;
        bit hit, on;
        if (!br) return 12'h000;
        if (in_grid(h, v)) begin
            col = (h - OX) / TS;  ox = (h - OX) % TS;
            row = (v - OY) / TS;  oy = (v - OY) % TS;
            hit = cx < GW && cy < GH && cx == col && cy == row &&
                  (ox < CT || ox >= TS - CT || oy < CT || oy >= TS - CT);
            on  = (gs == 0 || gs == 3) && !blink;
            if (hit && on) return 12'hF00;
            idx = sprite_of(int'(ram[row*GW + col]));
            if (idx < 0) return 12'hF0F;
            return rom_fn(14'(idx*1024 + oy*32 + ox));
        end
        if (h >= OX - BT && h < OX + GW*TS + BT && v >= OY - BT && v < OY + GH*TS + BT) begin
            if (gs == 1) return blink ? 12'h888 : 12'h0F0;
            if (gs == 2) return 12'hF00;
            return 12'h888;
        end
        return 12'hFFF;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_t z;
        adr_t d;
        z = '{12'h000, 1'b0};
        d = '{1'b0, 0, 1'b0, 14'd0};
        eq.delete();
        aq.delete();
        repeat (4) eq.push_back(z);
        repeat (2) aq.push_back(d);
        edge_k = 0;
        lat_cx = 0;
        lat_cy = 0;
    endtask

    // One pixel per clock; compares what the pipeline shows for the pixel
    // sampled four edges earlier, and the memory addresses of the last two.
    task automatic cycle(input int h, input int v, input bit br, input int cx, input int cy, input int gs);
        exp_t e;
        adr_t a;
        bit   blink;
        int   idx;
        hCount = 10'(h); vCount = 10'(v); bright = br;
        cursor_x = 4'(cx); cursor_y = 4'(cy); game_state = 2'(gs);
        blink = (((edge_k + 1) >> (BL - 1)) & 1) != 0;
        e.rgb = ref_rgb(h, v, br, lat_cx, lat_cy, gs, blink);
        e.br  = br;
        eq.push_back(e);
        a = '{1'b0, 0, 1'b0, 14'd0};
        if (in_grid(h, v)) begin
            a.cchk  = 1'b1;
            a.caddr = ((v - OY) / TS) * GW + (h - OX) / TS;
            idx = sprite_of(int'(ram[a.caddr]));
            if (idx >= 0) begin
                a.schk  = 1'b1;
                a.saddr = 14'(idx*1024 + ((v - OY) % TS)*32 + (h - OX) % TS);
            end
        end
        aq.push_back(a);
        if (h == 0 && v == 0) begin
            lat_cx = cx;
            lat_cy = cy;
        end
        @(posedge masterclk);
        #1;
        edge_k++;
        e = eq.pop_front();
        check("rgb", 32'(rgb), 32'(e.rgb));
        check("bright_out", 32'(bright_out), 32'(e.br));
        if (aq[1].cchk) check("cell_addr", 32'(cell_addr), 32'(aq[1].caddr));
        if (aq[0].schk) check("sprite_addr", 32'(sprite_addr), 32'(aq[0].saddr));
        a = aq.pop_front();
    endtask

    task automatic reset_pulse(input int n);
        rst = 1'b0;
        #1;
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_bright", 32'(bright_out), 32'h0);
        hCount = 10'd144; vCount = 10'd13; bright = 1'b1; game_state = 2'd0;
        repeat (n) begin
            @(posedge masterclk);
            #1;
            check("reset_hold_rgb", 32'(rgb), 32'h0);
            check("reset_hold_bright", 32'(bright_out), 32'h0);
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic add(input int h, input int v, input bit br, input int cx, input int cy,
                       input int gs, input int blk, input logic [11:0] exp, input string name);
        vec_t t;
        t.h = h; t.v = v; t.br = br; t.cx = cx; t.cy = cy;
        t.gs = gs; t.blk = blk; t.exp = exp; t.name = name;
        tbl.push_back(t);
    endtask

    initial begin
        int vl[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 16, 17};
        int guard, h, v, gs;
        bit br;

        for (int i = 0; i < 256; i++)
            ram[i] = ($urandom_range(0, 1) != 0) ? 5'(vl[$urandom_range(0, 12)]) : 5'($urandom_range(0, 31));
        ram[0]  = 5'b00011;
        ram[15] = 5'b10001;
        ram[18] = 5'b00001;
        ram[40] = 5'b11111;

        add(0,   0,   1, 2, 1, 0, 2, 12'hFFF, "frame_start");
        add(208, 45,  1, 2, 1, 0, 0, 12'hF00, "cursor_on");
        add(208, 45,  1, 2, 1, 0, 1, rom_fn({4'd1, 5'd0, 5'd0}), "cursor_blink_off");
        add(208, 45,  1, 5, 3, 0, 0, 12'hF00, "cursor_midframe_change");
        add(150, 20,  1, 5, 3, 0, 2, rom_fn({4'd3, 5'd7, 5'd6}), "cell0_num3");
        add(655, 13,  1, 5, 3, 0, 2, rom_fn({4'd11, 5'd0, 5'd31}), "col15_flag");
        add(656, 13,  1, 5, 3, 0, 2, 12'h888, "right_border");
        add(660, 13,  1, 5, 3, 0, 2, 12'hFFF, "past_border");
        add(405, 80,  1, 5, 3, 0, 2, 12'hF0F, "bad_code");
        add(141, 100, 1, 5, 3, 2, 2, 12'hF00, "lost_border");
        add(208, 45,  1, 5, 3, 2, 0, rom_fn({4'd1, 5'd0, 5'd0}), "lost_no_cursor");
        add(143, 12,  1, 5, 3, 1, 0, 12'h0F0, "won_border_on");
        add(143, 12,  1, 5, 3, 1, 1, 12'h888, "won_border_off");
        add(150, 20,  0, 5, 3, 0, 2, 12'h000, "blanked");
        add(208, 45,  1, 5, 3, 3, 0, 12'hF00, "reserved_as_play");
        add(0,   0,   1, 5, 0, 0, 2, 12'hFFF, "frame_start2");
        add(334, 44,  1, 5, 0, 0, 0, 12'hF00, "cursor_moved");
        add(208, 45,  1, 5, 0, 0, 0, rom_fn({4'd1, 5'd0, 5'd0}), "old_cursor_gone");
        add(143, 525, 1, 5, 0, 0, 2, 12'h888, "bottom_border");
        add(144, 13,  1, 5, 0, 0, 2, rom_fn({4'd3, 5'd0, 5'd0}), "origin_pixel");

        #2;
        model_reset();
        reset_pulse(3);
        repeat (6) cycle(144, 13, 1'b1, 0, 0, 0);

        foreach (tbl[i]) begin
            guard = 0;
            while (tbl[i].blk != 2 && ((((edge_k + 1) >> (BL - 1)) & 1) != tbl[i].blk) && guard < 40) begin
                cycle(1, 1, 1'b0, tbl[i].cx, tbl[i].cy, tbl[i].gs);
                guard++;
            end
            if (guard >= 40) begin
                nvec++;
                nmis++;
                $display("FAIL blink_align %s: got no phase %0d within 40 clocks", tbl[i].name, tbl[i].blk);
            end
            cycle(tbl[i].h, tbl[i].v, tbl[i].br, tbl[i].cx, tbl[i].cy, tbl[i].gs);
            repeat (4) cycle(1, 1, 1'b0, tbl[i].cx, tbl[i].cy, tbl[i].gs);
            check(tbl[i].name, 32'(rgb), 32'(tbl[i].exp));
        end

        repeat (24) cycle(141, 300, 1'b1, 0, 0, 1);

        gs = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) reset_pulse(2);
            if (i % 97 == 0) gs = int'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: begin h = 0; v = 0; end
                1, 2: begin
                    h = OX + lat_cx*TS + int'($urandom_range(0, TS - 1));
                    v = OY + lat_cy*TS + int'($urandom_range(0, TS - 1));
                end
                default: begin
                    h = int'($urandom_range(100, 720));
                    v = int'($urandom_range(0, 560));
                end
            endcase
            br = $urandom_range(0, 9) != 0;
            cycle(h, v, br, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), gs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before 2000000");
        $fatal(1);
    end

endmodule
`default_nettype wire
